// File: rtl/pending_write_cam.sv
// Pending-write CAM: tracks register IDs with outstanding long-latency
// writes and flags source operands that depend on them.
module pending_write_cam #(
  parameter int reg_addr_width_p = 5,
  parameter int els_p            = 4,
  parameter int num_src_p        = 3,
  parameter int num_clear_p      = 2,
  parameter int cnt_width_p      = 2
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  input  logic                                    alloc_v_i,
  input  logic [reg_addr_width_p-1:0]             alloc_id_i,
  output logic                                    alloc_ready_o,
  input  logic [num_clear_p-1:0]                  clear_v_i,
  input  logic [num_clear_p*reg_addr_width_p-1:0] clear_id_i,
  input  logic [num_src_p-1:0]                    src_v_i,
  input  logic [num_src_p*reg_addr_width_p-1:0]   src_id_i,
  output logic [num_src_p-1:0]                    dep_o,
  output logic [$clog2(els_p+1)-1:0]              count_o,
  output logic                                    full_o,
  output logic                                    empty_o,
  output logic                                    err_o
);

  localparam int W  = reg_addr_width_p;
  localparam int CW = $clog2(els_p+1);
  localparam int IW = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int EW = cnt_width_p + $clog2(num_clear_p+1) + 1;
  localparam logic [cnt_width_p-1:0] CMAX = '1;

  logic [W-1:0]           id_q  [els_p];
  logic [W-1:0]           id_d  [els_p];
  logic [cnt_width_p-1:0] cnt_q [els_p];
  logic [cnt_width_p-1:0] cnt_d [els_p];
  logic [EW-1:0]          nclr  [els_p];
  logic [els_p-1:0]       valid;
  logic [CW-1:0]          count_q, count_d;
  logic                   err_q, err_d;

  logic          a_hit, free_found, alloc_acc, a_nz;
  logic [IW-1:0] a_idx, free_idx;
  logic [cnt_width_p-1:0] a_cnt;

  always_comb begin
    for (int j = 0; j < els_p; j++) valid[j] = (cnt_q[j] != '0);
  end

  always_comb begin
    a_hit      = 1'b0;
    a_idx      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int j = 0; j < els_p; j++) begin
      if (!a_hit && valid[j] && id_q[j] == alloc_id_i) begin
        a_hit = 1'b1;
        a_idx = IW'(j);
      end
      if (!free_found && !valid[j]) begin
        free_found = 1'b1;
        free_idx   = IW'(j);
      end
    end
  end

  assign a_nz  = (alloc_id_i != '0);
  assign a_cnt = cnt_q[a_idx];

  assign alloc_ready_o = !a_nz
                       | (a_hit && a_cnt != CMAX)
                       | (!a_hit && !full_o);

  assign alloc_acc = alloc_v_i && alloc_ready_o && a_nz;

  always_comb begin : clr_p
    logic [W-1:0] cid;
    logic         chit;
    cid   = '0;
    chit  = 1'b0;
    err_d = err_q;
    for (int j = 0; j < els_p; j++) nclr[j] = '0;
    for (int k = 0; k < num_clear_p; k++) begin
      cid  = clear_id_i[k*W +: W];
      chit = 1'b0;
      if (clear_v_i[k] && cid != '0) begin
        for (int j = 0; j < els_p; j++) begin
          if (valid[j] && id_q[j] == cid) begin
            nclr[j] = nclr[j] + EW'(1);
            chit    = 1'b1;
          end
        end
        if (!chit) err_d = 1'b1;
      end
    end
    // Underflow is judged on the clears alone; a same-cycle alloc hit
    // does not rescue an over-cleared entry.
    for (int j = 0; j < els_p; j++) begin
      id_d[j]  = id_q[j];
      cnt_d[j] = cnt_q[j];
      if (valid[j]) begin
        if (nclr[j] > EW'(cnt_q[j])) begin
          cnt_d[j] = '0;
          err_d    = 1'b1;
        end else begin
          cnt_d[j] = cnt_width_p'(EW'(cnt_q[j])
                   + EW'(alloc_acc && a_hit && a_idx == IW'(j))
                   - nclr[j]);
        end
      end else if (alloc_acc && !a_hit && free_found
                   && free_idx == IW'(j)) begin
        id_d[j]  = alloc_id_i;
        cnt_d[j] = cnt_width_p'(1);
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int j = 0; j < els_p; j++)
      count_d = count_d + CW'(cnt_d[j] != '0);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int j = 0; j < els_p; j++) begin
        id_q[j]  <= '0;
        cnt_q[j] <= '0;
      end
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int j = 0; j < els_p; j++) begin
        id_q[j]  <= id_d[j];
        cnt_q[j] <= cnt_d[j];
      end
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    dep_o = '0;
    for (int i = 0; i < num_src_p; i++) begin
      for (int j = 0; j < els_p; j++) begin
        if (src_v_i[i] && src_id_i[i*W +: W] != '0
            && valid[j] && id_q[j] == src_id_i[i*W +: W])
          dep_o[i] = 1'b1;
      end
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(els_p));
  assign empty_o = (count_q == '0);
  assign err_o   = err_q;

endmodule

// File: tb/tb_pending_write_cam.sv
// Directed bench for pending_write_cam: alloc/clear/dep behaviour,
// capacity and counter limits, error stickiness and async reset.
module tb_pending_write_cam;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alloc_v;
  logic [4:0]  alloc_id;
  logic        alloc_ready;
  logic [1:0]  clear_v;
  logic [9:0]  clear_id;
  logic [2:0]  src_v;
  logic [14:0] src_id;
  logic [2:0]  dep;
  logic [2:0]  count;
  logic        full, empty, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pending_write_cam dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .alloc_v_i(alloc_v), .alloc_id_i(alloc_id),
    .alloc_ready_o(alloc_ready),
    .clear_v_i(clear_v), .clear_id_i(clear_id),
    .src_v_i(src_v), .src_id_i(src_id),
    .dep_o(dep), .count_o(count),
    .full_o(full), .empty_o(empty), .err_o(err)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_v  = 1'b0;
    alloc_id = '0;
    clear_v  = '0;
    clear_id = '0;
  endtask

  task automatic alloc(input logic [4:0] id);
    alloc_v  = 1'b1;
    alloc_id = id;
  endtask

  task automatic clr(input logic [1:0] v,
                     input logic [4:0] id0,
                     input logic [4:0] id1);
    clear_v  = v;
    clear_id = {id1, id0};
  endtask

  task automatic srcs(input logic [4:0] a,
                      input logic [4:0] b,
                      input logic [4:0] c);
    src_v  = 3'b111;
    src_id = {c, b, a};
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [4:0] ids [4];
    ids = '{5'd3, 5'd7, 5'd9, 5'd11};
    reset_n = 1'b0;
    idle();
    srcs(5'd0, 5'd0, 5'd0);
    #3;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_dep", dep, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    alloc(5'd5);
    #1 check("a5_ready", alloc_ready, 1);
    step();
    idle();
    srcs(5'd5, 5'd6, 5'd0);
    #1 check("a5_dep", dep, 3'b001);
    check("a5_count", count, 1);
    check("a5_empty", empty, 0);
    clr(2'b01, 5'd5, 5'd0);
    step();
    idle();
    check("c5_dep", dep, 0);
    check("c5_empty", empty, 1);
    check("c5_err", err, 0);

    for (int i = 0; i < 4; i++) begin
      alloc(ids[i]);
      step();
    end
    idle();
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    alloc(5'd13);
    #1 check("a13_noready", alloc_ready, 0);
    step();
    idle();
    srcs(5'd13, 5'd7, 5'd3);
    #1 check("a13_count", count, 4);
    check("a13_dep", dep, 3'b110);
    alloc(5'd7);
    #1 check("a7_hit_ready", alloc_ready, 1);
    step();
    idle();
    clr(2'b01, 5'd7, 5'd0);
    step();
    idle();
    check("c7a_count", count, 4);
    check("c7a_dep", dep, 3'b110);
    clr(2'b10, 5'd0, 5'd7);
    step();
    idle();
    check("c7b_count", count, 3);
    check("c7b_dep", dep, 3'b100);
    alloc(5'd13);
    #1 check("a13_ready", alloc_ready, 1);
    step();
    idle();
    check("a13b_full", full, 1);
    check("a13b_dep", dep, 3'b101);
    clr(2'b11, 5'd3, 5'd9);
    step();
    clr(2'b11, 5'd11, 5'd13);
    step();
    idle();
    check("drain_count", count, 0);
    check("drain_err", err, 0);

    alloc(5'd7);
    step();
    alloc(5'd7);
    clr(2'b11, 5'd7, 5'd7);
    #1 check("uf_ready", alloc_ready, 1);
    step();
    idle();
    srcs(5'd7, 5'd0, 5'd0);
    #1 check("uf_count", count, 0);
    check("uf_err", err, 1);
    check("uf_dep", dep, 0);

    do_reset();
    check("rst2_err", err, 0);
    clr(2'b10, 5'd0, 5'd20);
    step();
    idle();
    check("miss_err", err, 1);
    step();
    step();
    check("miss_sticky", err, 1);
    do_reset();
    check("rst3_err", err, 0);
    clr(2'b01, 5'd0, 5'd0);
    step();
    idle();
    check("clr0_err", err, 0);
    alloc(5'd0);
    #1 check("a0_ready", alloc_ready, 1);
    step();
    idle();
    check("a0_count", count, 0);
    check("a0_empty", empty, 1);

    for (int i = 0; i < 3; i++) begin
      alloc(5'd5);
      step();
    end
    #1 check("sat_ready", alloc_ready, 0);
    step();
    idle();
    clr(2'b11, 5'd5, 5'd5);
    step();
    idle();
    check("sat_c2_count", count, 1);
    clr(2'b01, 5'd5, 5'd0);
    step();
    idle();
    check("sat_c3_count", count, 0);
    check("sat_err", err, 0);

    alloc(5'd4);
    step();
    idle();
    srcs(5'd4, 5'd0, 5'd0);
    #1 check("a4_dep", dep, 3'b001);
    #2 reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_dep", dep, 0);
    check("arst_err", err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("post_dep", dep, 0);
    check("post_ready", alloc_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
